// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the PC / conditional-branch sequencer:
// default datapath widths and the branch FSM state encoding.
package branch_pc_unit_pkg;

  localparam int BPU_WIDTH   = 32;
  localparam int BPU_C_WIDTH = 19;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CON = 2'd1,
    ST_EVAL     = 2'd2
  } bpu_state_e;

endpackage

// File: rtl/branch_pc_unit_sign_ext.sv
// Two's-complement sign extension of a C_WIDTH immediate field to WIDTH bits;
// shared with the datapath immediate path.
module branch_pc_unit_sign_ext
  import branch_pc_unit_pkg::*;
#(
  parameter int WIDTH   = BPU_WIDTH,
  parameter int C_WIDTH = BPU_C_WIDTH
) (
  input  logic [C_WIDTH-1:0] c_i,
  output logic [WIDTH-1:0]   ext_o
);

  assign ext_o = {{(WIDTH-C_WIDTH){c_i[C_WIDTH-1]}}, c_i};

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with fetch increment, absolute load and a three-state
// conditional-branch sequencer that strobes the condition flop and applies the offset.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int               WIDTH    = BPU_WIDTH,
  parameter int               C_WIDTH  = BPU_C_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [WIDTH-1:0]   bus_in,
  input  logic               start,
  input  logic [C_WIDTH-1:0] ir_c,
  input  logic               con,
  output logic               con_en,
  output logic [WIDTH-1:0]   pc,
  output logic               busy,
  output logic               done,
  output logic               taken
);

  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  bpu_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] off_q, off_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic [WIDTH-1:0] off_ext_s;

  branch_pc_unit_sign_ext #(
    .WIDTH   (WIDTH),
    .C_WIDTH (C_WIDTH)
  ) u_sign_ext (
    .c_i   (ir_c),
    .ext_o (off_ext_s)
  );

  // Next-state logic; a start issued together with inc/load branches from the updated PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    off_d   = off_q;
    done_d  = 1'b0;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (pc_load) begin
          pc_d = bus_in;
        end else if (pc_inc) begin
          pc_d = pc_q + PC_ONE;
        end else begin
          pc_d = pc_q;
        end
        if (start) begin
          off_d   = off_ext_s;
          state_d = ST_WAIT_CON;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_CON: begin
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        done_d  = 1'b1;
        taken_d = con;
        if (con) begin
          pc_d = pc_q + off_q;
        end else begin
          pc_d = pc_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; clr aborts any branch in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      off_q   <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
      done_q  <= done_d;
      taken_q <= taken_d;
    end
  end

  assign con_en = (state_q == ST_WAIT_CON);
  assign busy   = (state_q == ST_WAIT_CON) || (state_q == ST_EVAL);
  assign pc     = pc_q;
  assign done   = done_q;
  assign taken  = taken_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: expected branch results are queued when a
// branch is issued and popped when done pulses.
module tb_branch_pc_unit;

  logic        clk;
  logic        clr;
  logic        pc_inc;
  logic        pc_load;
  logic [31:0] bus_in;
  logic        start;
  logic [18:0] ir_c;
  logic        con;
  logic        con_en;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        taken;

  int total;
  int bad;

  logic [31:0] sb_pc[$];
  logic        sb_tk[$];

  branch_pc_unit dut (
    .clk     (clk),
    .clr     (clr),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .bus_in  (bus_in),
    .start   (start),
    .ir_c    (ir_c),
    .con     (con),
    .con_en  (con_en),
    .pc      (pc),
    .busy    (busy),
    .done    (done),
    .taken   (taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load = 1'b1;
    bus_in  = v;
    tick();
    pc_load = 1'b0;
    check("load_pc", pc, v);
  endtask

  // Issue one branch, observe con_en/busy per cycle, then check the queued result.
  task automatic branch(input string tag, input logic [18:0] c, input logic cv, input logic inc,
                        input logic poke, input logic [31:0] exp_pc, input logic exp_tk);
    int   ncon;
    int   nbusy;
    logic seen;
    logic [31:0] e_pc;
    logic        e_tk;
    sb_pc.push_back(exp_pc);
    sb_tk.push_back(exp_tk);
    start  = 1'b1;
    ir_c   = c;
    pc_inc = inc;
    tick();
    start  = 1'b0;
    pc_inc = 1'b0;
    ir_c   = 19'($urandom);
    con    = ~cv;
    if (poke) begin
      pc_inc  = 1'b1;
      pc_load = 1'b1;
      bus_in  = 32'hDEAD_BEEF;
      start   = 1'b1;
    end
    ncon  = 0;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (con_en) ncon++;
      if (busy) nbusy++;
      if (busy && !con_en) con = cv;
      if (done) seen = 1'b1;
      else tick();
    end
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    start   = 1'b0;
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
    if (seen) begin
      total++;
      assert (sb_pc.size() > 0) else begin
        bad++;
        $error("FAIL %s_sb_empty observed=0 expected=1", tag);
      end
      if (sb_pc.size() > 0) begin
        e_pc = sb_pc.pop_front();
        e_tk = sb_tk.pop_front();
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_taken"}, {31'd0, taken}, {31'd0, e_tk});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
      check({tag, "_con_en_cycles"}, ncon, 32'd1);
      check({tag, "_busy_cycles"}, nbusy, 32'd2);
      tick();
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_pc_after"}, pc, exp_pc);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    clr     = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    bus_in  = 32'd0;
    start   = 1'b0;
    ir_c    = 19'd0;
    con     = 1'b0;

    // reset from an arbitrary pc
    tick();
    load_pc(32'h1234_5678);
    clr     = 1'b1;
    pc_inc  = 1'b1;
    pc_load = 1'b1;
    bus_in  = 32'hAAAA_5555;
    tick();
    clr     = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    check("rst_pc", pc, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_con_en", {31'd0, con_en}, 32'd0);

    // increment wrap and load priority over inc
    load_pc(32'hFFFF_FFFF);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("inc_wrap", pc, 32'h0000_0000);
    pc_inc  = 1'b1;
    pc_load = 1'b1;
    bus_in  = 32'h0000_0100;
    tick();
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    check("load_over_inc", pc, 32'h0000_0100);
    tick();
    check("idle_hold", pc, 32'h0000_0100);

    load_pc(32'h0000_0010);
    branch("fwd", 19'h00005, 1'b1, 1'b0, 1'b0, 32'h0000_0015, 1'b1);

    load_pc(32'h0000_0010);
    branch("back", 19'h7FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_000E, 1'b1);

    load_pc(32'h0000_0020);
    branch("nt_inc", 19'h00005, 1'b0, 1'b1, 1'b1, 32'h0000_0021, 1'b0);

    load_pc(32'hFFFF_FFFF);
    branch("wrap_add", 19'h00003, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b1);

    load_pc(32'h0000_0000);
    branch("neg_min", 19'h40000, 1'b1, 1'b0, 1'b0, 32'hFFFC_0000, 1'b1);

    // abort in WAIT_CON
    load_pc(32'h0000_0040);
    start = 1'b1;
    ir_c  = 19'h00003;
    con   = 1'b1;
    tick();
    start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_pc", pc, 32'd0);
    check("abort_busy_clr", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      check("abort_pc_hold", pc, 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
